// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO map, STATUS layout, region decode.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package dmem_pkg;

   // MMIO word offsets within the 16-byte window (dAddress[3:2])
   localparam logic [1:0] MMIO_GPIO   = 2'd0;
   localparam logic [1:0] MMIO_CYCLE  = 2'd1;
   localparam logic [1:0] MMIO_STATUS = 2'd2;
   localparam logic [1:0] MMIO_ERRCLR = 2'd3;

   // Bit positions of the sticky error flags in STATUS and in ERRCLR
   localparam int ST_MISALIGN = 0;
   localparam int ST_OOB      = 1;
   localparam int ST_PROTO    = 2;

   localparam int ERR_W = 3;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_NONE
   } region_e;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } resp_state_e;

   // Half-open window test done in 33 bits so base+size never wraps
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] size);
      logic [32:0] a33;
      logic [32:0] b33;
      a33 = {1'b0, addr};
      b33 = {1'b0, base};
      return (a33 >= b33) && (a33 < (b33 + size));
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-responder data-memory bus: request, address, store data, load data, response strobe.
// Latency: n/a (signal bundle only).
// Backpressure: none; the responder accepts one request every cycle.
interface data_mem_responder_if;

   logic        MemRead;
   logic        MemWrite;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;
   logic        rd_valid;

   modport master (
      output MemRead, MemWrite, dAddress, dWriteData,
      input  dReadData, rd_valid
   );

   modport slave (
      input  MemRead, MemWrite, dAddress, dWriteData,
      output dReadData, rd_valid
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and synchronous, enable-gated read.
// Latency: read data valid after the edge that samples re_i; write commits on the same edge.
// Backpressure: none; the read register holds its value while re_i is low.
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Storage and read register; no reset so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes core loads/stores into word RAM or the MMIO window, flags bad accesses.
// Latency: load data and rd_valid appear one edge after MemRead; stores commit on the sampling edge.
// Backpressure: none; every request is consumed in the cycle it is presented.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic                clk,
   input  logic                rst,
   data_mem_responder_if.slave bus,
   output logic [31:0]         gpio_out,
   output logic                err_misalign,
   output logic                err_oob,
   output logic                err_proto
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RAM_BYTES  = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [32:0] MMIO_BYTES = 33'd16;

   // Request decode
   logic            req_rd;
   logic            req_wr;
   logic            proto_hit;
   logic            misalign_hit;
   logic            oob_hit;
   logic            access_ok;
   region_e         region;
   logic [1:0]      mmio_off;
   logic [31:0]     ram_off;
   logic [AW-1:0]   ram_idx;
   logic            unused_ram_off_bits;

   // RAM port
   logic            ram_we;
   logic            ram_re;
   logic [31:0]     ram_rdata;

   // Architectural state
   resp_state_e     state_q, state_d;
   logic [31:0]     gpio_q, gpio_d;
   logic [31:0]     cycle_q, cycle_d;
   logic [15:0]     acc_q, acc_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [ERR_W-1:0] err_set;
   logic [ERR_W-1:0] err_clr;
   logic            rd_src_ram_q, rd_src_ram_d;
   logic [31:0]     rd_dat_q, rd_dat_d;
   logic [31:0]     mmio_rdata;
   logic [31:0]     status_word;

   assign req_rd   = bus.MemRead;
   assign req_wr   = bus.MemWrite;
   assign mmio_off = bus.dAddress[3:2];
   assign ram_off  = bus.dAddress - DATA_BASE;
   assign ram_idx  = ram_off[AW+1:2];
   // Upper offset bits are range-checked by the window compare, low bits by the alignment check
   assign unused_ram_off_bits = ^{ram_off[31:AW+2], ram_off[1:0]};

   // Priority decode: protocol error, then alignment, then region windows
   always_comb begin
      region       = REG_NONE;
      proto_hit    = 1'b0;
      misalign_hit = 1'b0;
      oob_hit      = 1'b0;
      access_ok    = 1'b0;
      err_set      = '0;
      if (in_window(bus.dAddress, DATA_BASE, RAM_BYTES)) begin
         region = REG_RAM;
      end else if (in_window(bus.dAddress, MMIO_BASE, MMIO_BYTES)) begin
         region = REG_MMIO;
      end
      if (req_rd && req_wr) begin
         proto_hit = 1'b1;
      end else if (req_rd || req_wr) begin
         if (bus.dAddress[1:0] != 2'b00) begin
            misalign_hit = 1'b1;
         end else if (region == REG_NONE) begin
            oob_hit = 1'b1;
         end else begin
            access_ok = 1'b1;
         end
      end
      err_set[ST_PROTO]    = proto_hit;
      err_set[ST_MISALIGN] = misalign_hit;
      err_set[ST_OOB]      = oob_hit;
   end

   // A store racing an asserted reset must not reach the array, which is not reset
   assign ram_we = access_ok && req_wr && (region == REG_RAM) && !rst;
   assign ram_re = access_ok && req_rd && (region == REG_RAM);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_idx),
      .wdata_i (bus.dWriteData),
      .rdata_o (ram_rdata)
   );

   assign status_word = {acc_q, 13'd0, err_q[ST_PROTO], err_q[ST_OOB], err_q[ST_MISALIGN]};

   // MMIO read mux; ERRCLR is write-only and reads as zero
   always_comb begin
      mmio_rdata = 32'd0;
      case (mmio_off)
         MMIO_GPIO:   mmio_rdata = gpio_q;
         MMIO_CYCLE:  mmio_rdata = cycle_q;
         MMIO_STATUS: mmio_rdata = status_word;
         default:     mmio_rdata = 32'd0;
      endcase
   end

   // Register next-state: GPIO, sticky errors (set beats clear), counters, load-data source
   always_comb begin
      gpio_d       = gpio_q;
      err_clr      = '0;
      cycle_d      = cycle_q + 32'd1;
      acc_d        = acc_q;
      rd_src_ram_d = rd_src_ram_q;
      rd_dat_d     = rd_dat_q;

      if (access_ok && req_wr && (region == REG_MMIO)) begin
         if (mmio_off == MMIO_GPIO) begin
            gpio_d = bus.dWriteData;
         end
         if (mmio_off == MMIO_ERRCLR) begin
            err_clr = bus.dWriteData[ERR_W-1:0];
         end
      end

      err_d = (err_q & ~err_clr) | err_set;

      if (access_ok && (acc_q != 16'hFFFF)) begin
         acc_d = acc_q + 16'd1;
      end

      // Every read, good or bad, replaces the held load data
      if (req_rd) begin
         rd_src_ram_d = access_ok && (region == REG_RAM);
         rd_dat_d     = (access_ok && (region == REG_MMIO)) ? mmio_rdata : 32'd0;
      end
   end

   // Response FSM: RESP marks the single cycle after a read request
   always_comb begin
      state_d      = ST_IDLE;
      bus.rd_valid = 1'b0;
      if (req_rd) begin
         state_d = ST_RESP;
      end
      if (state_q == ST_RESP) begin
         bus.rd_valid = 1'b1;
      end
   end

   // State registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gpio_q       <= 32'd0;
         cycle_q      <= 32'd0;
         acc_q        <= 16'd0;
         err_q        <= '0;
         rd_src_ram_q <= 1'b0;
         rd_dat_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         gpio_q       <= gpio_d;
         cycle_q      <= cycle_d;
         acc_q        <= acc_d;
         err_q        <= err_d;
         rd_src_ram_q <= rd_src_ram_d;
         rd_dat_q     <= rd_dat_d;
      end
   end

   // RAM loads come straight from the array read register, everything else from rd_dat_q
   assign bus.dReadData = rd_src_ram_q ? ram_rdata : rd_dat_q;

   assign gpio_out     = gpio_q;
   assign err_misalign = err_q[ST_MISALIGN];
   assign err_oob      = err_q[ST_OOB];
   assign err_proto    = err_q[ST_PROTO];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic against a behavioural model.
// Latency: inputs driven on negedge, outputs checked on the following negedge.
// Backpressure: n/a.
module tb_data_mem_responder;

   localparam logic [31:0] DB    = 32'h1001_0000;
   localparam logic [31:0] MB    = 32'hFFFF_0000;
   localparam int          DEPTH = 256;

   logic        clk;
   logic        rst;
   logic [31:0] gpio_out;
   logic        err_misalign;
   logic        err_oob;
   logic        err_proto;

   int checks = 0;
   int errors = 0;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .DATA_BASE   (DB),
      .DEPTH_WORDS (DEPTH),
      .MMIO_BASE   (MB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .gpio_out     (gpio_out),
      .err_misalign (err_misalign),
      .err_oob      (err_oob),
      .err_proto    (err_proto)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_gpio;
   logic [2:0]  m_err;      // {proto, oob, misalign}
   int          m_acc;
   logic [31:0] m_cyc;
   logic [31:0] m_rd_last;

   // Free-running count of clock edges since reset was released
   always @(posedge clk or posedge rst) begin
      if (rst) m_cyc <= 32'd0;
      else     m_cyc <= m_cyc + 32'd1;
   end

   task automatic model_reset;
      m_gpio    = 32'd0;
      m_err     = 3'b000;
      m_acc     = 0;
      m_rd_last = 32'd0;
   endtask

   task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] res);
      int  idx;
      bit  ok;
      res = 32'd0;
      ok  = 1'b0;
      if (r && w) begin
         m_err[2] = 1'b1;
      end else if (r || w) begin
         if ((a % 4) != 0) begin
            m_err[0] = 1'b1;
         end else if (a >= DB && a < DB + 4 * DEPTH) begin
            idx = int'((a - DB) / 4);
            if (w) m_mem[idx] = d;
            else   res = m_mem[idx];
            ok = 1'b1;
         end else if (a >= MB && a < MB + 16) begin
            case ((a - MB) / 4)
               0: if (w) m_gpio = d; else res = m_gpio;
               1: if (r) res = m_cyc;
               2: if (r) res = {m_acc[15:0], 13'd0, m_err};
               default: if (w) m_err = m_err & ~d[2:0];
            endcase
            ok = 1'b1;
         end else begin
            m_err[1] = 1'b1;
         end
         if (ok && m_acc < 65535) m_acc = m_acc + 1;
      end
      if (r) m_rd_last = res;
   endtask

   // Presents one request for one edge; called and returns on a negedge
   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] exp);
      model_step(r, w, a, d, exp);
      bus.MemRead    = r;
      bus.MemWrite   = w;
      bus.dAddress   = a;
      bus.dWriteData = d;
      @(posedge clk);
      @(negedge clk);
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      checks++; if (bus.dReadData !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.dReadData); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
      checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
      checks++; if ({err_proto, err_oob, err_misalign} !== 3'b000) begin
         errors++; $display("FAIL reset_err got=%b exp=000", {err_proto, err_oob, err_misalign});
      end
   endtask

   task automatic fill_ram;
      logic [31:0] e;
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, DB + 32'(4 * i), $urandom, e);
   endtask

   task automatic test_ram_rw;
      logic [31:0] e;
      drive(1'b0, 1'b1, DB + 32'h4, 32'h1234_5678, e);
      drive(1'b1, 1'b0, DB + 32'h4, 32'd0, e);
      checks++; if (bus.dReadData !== 32'h1234_5678 || e !== 32'h1234_5678) begin
         errors++; $display("FAIL ram_read got=%h exp=12345678", bus.dReadData);
      end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL ram_rd_valid got=%b exp=1", bus.rd_valid); end
      @(negedge clk);
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got=%b exp=0", bus.rd_valid); end
      checks++; if (bus.dReadData !== 32'h1234_5678) begin errors++; $display("FAIL rdata_hold got=%h exp=12345678", bus.dReadData); end
      // last word of the RAM window
      drive(1'b0, 1'b1, DB + 32'(4 * DEPTH - 4), 32'hFEED_F00D, e);
      drive(1'b1, 1'b0, DB + 32'(4 * DEPTH - 4), 32'd0, e);
      checks++; if (bus.dReadData !== 32'hFEED_F00D) begin errors++; $display("FAIL ram_last_word got=%h exp=feedf00d", bus.dReadData); end
   endtask

   task automatic test_gpio;
      logic [31:0] e;
      drive(1'b0, 1'b1, MB, 32'h0000_00A5, e);
      checks++; if (gpio_out !== 32'h0000_00A5) begin errors++; $display("FAIL gpio_out got=%h exp=000000a5", gpio_out); end
      drive(1'b1, 1'b0, MB, 32'd0, e);
      checks++; if (bus.dReadData !== 32'h0000_00A5) begin errors++; $display("FAIL gpio_read got=%h exp=000000a5", bus.dReadData); end
   endtask

   task automatic test_misalign;
      logic [31:0] e;
      drive(1'b1, 1'b0, DB + 32'h2, 32'd0, e);
      checks++; if (bus.dReadData !== 32'd0) begin errors++; $display("FAIL misalign_rdata got=%h exp=0", bus.dReadData); end
      checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got=%b exp=1", err_misalign); end
      drive(1'b0, 1'b1, MB + 32'hC, 32'h1, e);
      checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear got=%b exp=0", err_misalign); end
   endtask

   task automatic test_proto;
      logic [31:0] e;
      drive(1'b1, 1'b1, DB, 32'hDEAD_BEEF, e);
      checks++; if (bus.dReadData !== 32'd0) begin errors++; $display("FAIL proto_rdata got=%h exp=0", bus.dReadData); end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL proto_rd_valid got=%b exp=1", bus.rd_valid); end
      checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL proto_set got=%b exp=1", err_proto); end
      drive(1'b1, 1'b0, DB, 32'd0, e);
      checks++; if (bus.dReadData !== e) begin errors++; $display("FAIL proto_ram_unchanged got=%h exp=%h", bus.dReadData, e); end
   endtask

   task automatic test_oob;
      logic [31:0] e;
      logic [31:0] addrs [4];
      addrs[0] = 32'h0;
      addrs[1] = DB + 32'(4 * DEPTH);
      addrs[2] = DB - 32'h4;
      addrs[3] = MB + 32'h10;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, MB + 32'hC, 32'h2, e);
         drive(1'b1, 1'b0, addrs[i], 32'd0, e);
         checks++; if (err_oob !== 1'b1 || bus.dReadData !== 32'd0) begin
            errors++; $display("FAIL oob_%0d got=%b/%h exp=1/0", i, err_oob, bus.dReadData);
         end
      end
      // clearing other bits must leave oob sticky
      drive(1'b0, 1'b1, MB + 32'hC, 32'h5, e);
      checks++; if (err_oob !== 1'b1 || err_proto !== 1'b0) begin
         errors++; $display("FAIL errclr_select got=oob%b proto%b exp=oob1 proto0", err_oob, err_proto);
      end
      drive(1'b0, 1'b1, MB + 32'hC, 32'h2, e);
      checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_clear got=%b exp=0", err_oob); end
   endtask

   task automatic test_mmio_regs;
      logic [31:0] e;
      drive(1'b1, 1'b0, MB + 32'h4, 32'd0, e);
      checks++; if (bus.dReadData !== e) begin errors++; $display("FAIL cycle_read got=%h exp=%h", bus.dReadData, e); end
      drive(1'b0, 1'b1, MB + 32'h4, 32'h0, e);
      drive(1'b1, 1'b0, MB + 32'h4, 32'd0, e);
      checks++; if (bus.dReadData !== e) begin errors++; $display("FAIL cycle_ro got=%h exp=%h", bus.dReadData, e); end
      drive(1'b1, 1'b0, 32'h0000_0100, 32'd0, e);
      drive(1'b1, 1'b0, MB + 32'h8, 32'd0, e);
      checks++; if (bus.dReadData !== e) begin errors++; $display("FAIL status_read got=%h exp=%h", bus.dReadData, e); end
      drive(1'b1, 1'b0, MB + 32'hC, 32'd0, e);
      checks++; if (bus.dReadData !== 32'd0) begin errors++; $display("FAIL errclr_read got=%h exp=0", bus.dReadData); end
   endtask

   task automatic test_random;
      logic [31:0] e, a, d;
      logic        r, w;
      int          sel, op;
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         op  = $urandom_range(0, 15);
         d   = $urandom;
         if (sel <= 5)      a = DB + 32'(4 * $urandom_range(0, DEPTH - 1));
         else if (sel <= 7) a = MB + 32'(4 * $urandom_range(0, 3));
         else if (sel == 8) a = DB + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         else               a = (op[0]) ? DB + 32'(4 * DEPTH) : 32'($urandom) & 32'h0FFF_FFFC;
         r = (op == 0) || (op < 8);
         w = (op == 0) || (op >= 8);
         drive(r, w, a, d, e);
         checks++; if (bus.dReadData !== m_rd_last) begin
            errors++; $display("FAIL rnd_rdata n=%0d a=%h got=%h exp=%h", n, a, bus.dReadData, m_rd_last);
         end
         checks++; if (bus.rd_valid !== r) begin errors++; $display("FAIL rnd_rd_valid n=%0d got=%b exp=%b", n, bus.rd_valid, r); end
         checks++; if ({err_proto, err_oob, err_misalign} !== m_err) begin
            errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, {err_proto, err_oob, err_misalign}, m_err);
         end
         checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL rnd_gpio n=%0d got=%h exp=%h", n, gpio_out, m_gpio); end
      end
      drive(1'b1, 1'b0, MB + 32'h8, 32'd0, e);
      checks++; if (bus.dReadData !== e) begin errors++; $display("FAIL rnd_status got=%h exp=%h", bus.dReadData, e); end
   endtask

   task automatic test_reset_midwrite;
      logic [31:0] e;
      drive(1'b0, 1'b1, MB, 32'h0000_0077, e);
      drive(1'b0, 1'b1, DB + 32'h40, 32'hCAFE_0001, e);
      drive(1'b1, 1'b0, 32'h0, 32'd0, e);
      drive(1'b1, 1'b0, DB + 32'h40, 32'd0, e);
      checks++; if (bus.dReadData !== 32'hCAFE_0001 || bus.rd_valid !== 1'b1) begin
         errors++; $display("FAIL pre_reset_read got=%h/%b exp=cafe0001/1", bus.dReadData, bus.rd_valid);
      end
      bus.MemWrite   = 1'b1;
      bus.dAddress   = DB + 32'h40;
      bus.dWriteData = 32'h0BAD_0BAD;
      #3;
      rst = 1'b1;
      #1;
      checks++; if (bus.dReadData !== 32'd0 || bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_async_bus got=%h/%b exp=0/0", bus.dReadData, bus.rd_valid);
      end
      checks++; if (gpio_out !== 32'd0 || {err_proto, err_oob, err_misalign} !== 3'b000) begin
         errors++; $display("FAIL reset_async_regs got=%h/%b exp=0/000", gpio_out, {err_proto, err_oob, err_misalign});
      end
      @(negedge clk);
      bus.MemWrite = 1'b0;
      model_reset();
      rst = 1'b0;
      drive(1'b1, 1'b0, DB + 32'h40, 32'd0, e);
      checks++; if (bus.dReadData !== 32'hCAFE_0001) begin errors++; $display("FAIL reset_no_commit got=%h exp=cafe0001", bus.dReadData); end
      drive(1'b1, 1'b0, MB + 32'h8, 32'd0, e);
      checks++; if (bus.dReadData !== 32'h0001_0000) begin errors++; $display("FAIL reset_acc_count got=%h exp=00010000", bus.dReadData); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.dAddress   = 32'd0;
      bus.dWriteData = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      fill_ram();
      test_ram_rw();
      test_gpio();
      test_misalign();
      test_proto();
      test_oob();
      test_mmio_regs();
      test_random();
      test_reset_midwrite();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
